// File: rtl/serial_loader.sv
// Serial-to-parallel loader: shifts WIDTH bits in MSB-first and pulses load with D for a downstream enabled register.
// Optional even-parity checking is compiled in with `define SERIAL_LOADER_PARITY_EN.
module serial_loader #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sin,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] D,
    output logic             load,
    output logic             perr
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_LOADER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH:0]    shcat;
    logic [WIDTH-1:0]  shnext;
    logic              last_bit;
    logic              unused_msb;

    // Concatenate-then-truncate keeps the shift legal for WIDTH=1 as well.
    assign shcat      = {shreg, sin};
    assign shnext     = shcat[WIDTH-1:0];
    assign unused_msb = shcat[WIDTH];
    assign last_bit   = (cnt == LAST);

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = SHIFT;
`ifdef SERIAL_LOADER_PARITY_EN
            SHIFT: if (last_bit) state_nxt = PAR;
            PAR:   state_nxt = IDLE;
`else
            SHIFT: if (last_bit) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            shreg <= '0;
            D     <= '0;
            load  <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
            perr  <= 1'b0;
`endif
        end else begin
            load <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
            perr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        shreg <= '0;
                    end
                end
                SHIFT: begin
                    shreg <= shnext;
                    cnt   <= cnt + 1'b1;
`ifndef SERIAL_LOADER_PARITY_EN
                    if (last_bit) begin
                        D    <= shnext;
                        load <= 1'b1;
                    end
`endif
                end
`ifdef SERIAL_LOADER_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to zero.
                PAR: begin
                    if (^{shreg, sin} == 1'b0) begin
                        D    <= shreg;
                        load <= 1'b1;
                    end else begin
                        perr <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef SERIAL_LOADER_PARITY_EN
    assign perr = 1'b0;
`endif

endmodule
